alu_unit: RTL and testbench

- Execute stage behind the reservation station: consumes the per-cycle dispatch bundle (op, Vi, Vj, imm, ROB id, pc) and broadcasts the result on the ALU result bus (ready, ROB id, value), which feeds back into RS/LSB/ROB dependency wake-up.
- Executes RV32I integer/branch/jump ops and RV32M ops; simple ops and MUL* are single-cycle, DIV/REM run on an iterative radix-2 divider with a busy back-pressure signal to the RS.
- Branch/jump resolution (taken, target) reported alongside the result for the ROB.

---
 rtl/alu_unit.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_alu_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - RV32IM execute stage with single-cycle ALU/multiplier and iterative radix-2 divider
//
// Consumes one dispatch bundle per cycle from the reservation station and
// broadcasts the result one cycle later (or DIV_CYCLES+1 cycles later for a
// real division) on the ALU result bus.
//
// Ports:
//   clk_in      system clock
//   rst_in      synchronous active-high reset
//   rdy_in      global ready; low freezes all state and outputs
//   clear_flag  misprediction flush, same effect as reset
//   alu_op      [6] selects imm as operand B, [5:0] op code (0 = NOP)
//   Vi, Vj, imm operand A, register operand B, immediate
//   rd          destination ROB id
//   pc          instruction pc
//   busy        combinational back-pressure to the RS
//   rs_ready    one-cycle result valid pulse
//   rs_ROB_id   ROB id of the result
//   rs_val      result value
//   br_valid    result belongs to a branch/JAL/JALR
//   br_taken    branch taken (always 1 for JAL/JALR)
//   br_target   resolved target pc
module alu_unit #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear_flag,
    input  logic [6:0]  alu_op,
    input  logic [31:0] Vi,
    input  logic [31:0] Vj,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic [31:0] pc,
    output logic        busy,
    output logic        rs_ready,
    output logic [4:0]  rs_ROB_id,
    output logic [31:0] rs_val,
    output logic        br_valid,
    output logic        br_taken,
    output logic [31:0] br_target
);

    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

    localparam logic [5:0] OP_ADD    = 6'd1;
    localparam logic [5:0] OP_SUB    = 6'd2;
    localparam logic [5:0] OP_SLL    = 6'd3;
    localparam logic [5:0] OP_SLT    = 6'd4;
    localparam logic [5:0] OP_SLTU   = 6'd5;
    localparam logic [5:0] OP_XOR    = 6'd6;
    localparam logic [5:0] OP_SRL    = 6'd7;
    localparam logic [5:0] OP_SRA    = 6'd8;
    localparam logic [5:0] OP_OR     = 6'd9;
    localparam logic [5:0] OP_AND    = 6'd10;
    localparam logic [5:0] OP_LUI    = 6'd11;
    localparam logic [5:0] OP_AUIPC  = 6'd12;
    localparam logic [5:0] OP_JAL    = 6'd13;
    localparam logic [5:0] OP_JALR   = 6'd14;
    localparam logic [5:0] OP_BEQ    = 6'd15;
    localparam logic [5:0] OP_BNE    = 6'd16;
    localparam logic [5:0] OP_BLT    = 6'd17;
    localparam logic [5:0] OP_BGE    = 6'd18;
    localparam logic [5:0] OP_BLTU   = 6'd19;
    localparam logic [5:0] OP_BGEU   = 6'd20;
    localparam logic [5:0] OP_MUL    = 6'd21;
    localparam logic [5:0] OP_MULH   = 6'd22;
    localparam logic [5:0] OP_MULHSU = 6'd23;
    localparam logic [5:0] OP_MULHU  = 6'd24;
    localparam logic [5:0] OP_DIV    = 6'd25;
    localparam logic [5:0] OP_DIVU   = 6'd26;
    localparam logic [5:0] OP_REM    = 6'd27;
    localparam logic [5:0] OP_REMU   = 6'd28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    div_state_t state, state_next;

    // ---------------- operand decode ----------------
    logic [5:0]  op;
    logic [31:0] opb;
    logic [4:0]  shamt;

    assign op    = alu_op[5:0];
    assign opb   = alu_op[6] ? imm : Vj;
    assign shamt = opb[4:0];

    // ---------------- divide-family classification ----------------
    logic is_div, div_signed, div_is_rem, div_by_zero, div_ovf, div_special;
    logic start_div, can_accept;
    logic [31:0] div_special_val;

    assign is_div      = (op >= OP_DIV) && (op <= OP_REMU);
    assign div_signed  = (op == OP_DIV) || (op == OP_REM);
    assign div_is_rem  = (op == OP_REM) || (op == OP_REMU);
    assign div_by_zero = (opb == 32'd0);
    assign div_ovf     = div_signed && (Vi == 32'h8000_0000) && (opb == 32'hFFFF_FFFF);
    assign div_special = div_by_zero || div_ovf;

    // While the divider iterates the RS is stalled; anything presented anyway is dropped.
    assign can_accept  = (state != S_RUN);
    assign start_div   = can_accept && is_div && !div_special;
    assign busy        = (state == S_RUN) || (is_div && !div_special);

    always_comb begin
        div_special_val = 32'd0;
        if (div_by_zero) begin
            div_special_val = div_is_rem ? Vi : 32'hFFFF_FFFF;
        end else begin
            div_special_val = div_is_rem ? 32'd0 : 32'h8000_0000;
        end
    end

    // ---------------- multiplier ----------------
    // One 64-bit product serves all four variants: sign- or zero-extending the
    // operands to 64 bits gives the right product modulo 2^64.
    logic [63:0] mul_a, mul_b, mul_p;

    assign mul_a = (op == OP_MULH || op == OP_MULHSU) ? {{32{Vi[31]}}, Vi} : {32'd0, Vi};
    assign mul_b = (op == OP_MULH) ? {{32{opb[31]}}, opb} : {32'd0, opb};
    assign mul_p = mul_a * mul_b;

    // ---------------- branch condition ----------------
    logic br_cond;

    always_comb begin
        br_cond = 1'b0;
        case (op)
            OP_BEQ:  br_cond = (Vi == opb);
            OP_BNE:  br_cond = (Vi != opb);
            OP_BLT:  br_cond = ($signed(Vi) <  $signed(opb));
            OP_BGE:  br_cond = ($signed(Vi) >= $signed(opb));
            OP_BLTU: br_cond = (Vi <  opb);
            OP_BGEU: br_cond = (Vi >= opb);
            default: br_cond = 1'b0;
        endcase
    end

    // ---------------- single-cycle result ----------------
    logic        sc_valid, sc_br, sc_taken;
    logic [31:0] sc_val, sc_target;

    always_comb begin
        sc_valid  = 1'b1;
        sc_val    = 32'd0;
        sc_br     = 1'b0;
        sc_taken  = 1'b0;
        sc_target = 32'd0;
        case (op)
            OP_ADD:    sc_val = Vi + opb;
            OP_SUB:    sc_val = Vi - opb;
            OP_SLL:    sc_val = Vi << shamt;
            OP_SLT:    sc_val = {31'd0, $signed(Vi) < $signed(opb)};
            OP_SLTU:   sc_val = {31'd0, Vi < opb};
            OP_XOR:    sc_val = Vi ^ opb;
            OP_SRL:    sc_val = Vi >> shamt;
            OP_SRA:    sc_val = $unsigned($signed(Vi) >>> shamt);
            OP_OR:     sc_val = Vi | opb;
            OP_AND:    sc_val = Vi & opb;
            OP_LUI:    sc_val = imm;
            OP_AUIPC:  sc_val = pc + imm;
            OP_JAL: begin
                sc_val    = pc + 32'd4;
                sc_br     = 1'b1;
                sc_taken  = 1'b1;
                sc_target = pc + imm;
            end
            OP_JALR: begin
                sc_val    = pc + 32'd4;
                sc_br     = 1'b1;
                sc_taken  = 1'b1;
                sc_target = (Vi + imm) & ~32'd1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                sc_br     = 1'b1;
                sc_taken  = br_cond;
                sc_target = br_cond ? (pc + imm) : (pc + 32'd4);
            end
            OP_MUL:                        sc_val = mul_p[31:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  sc_val = mul_p[63:32];
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                // Only the corner cases finish here; the rest go to the divider.
                sc_valid = div_special;
                sc_val   = div_special_val;
            end
            default:   sc_valid = 1'b0;
        endcase
    end

    // ---------------- iterative divider datapath ----------------
    logic [31:0]      div_rem, div_quo, div_dvs;
    logic [CNT_W-1:0] div_cnt;
    logic             div_neg_q, div_neg_r, div_rem_op;
    logic [4:0]       div_rd;
    logic             div_last;

    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] rem_next, quo_next, quo_final, rem_final;
    logic [31:0] a_mag, b_mag;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor when it fits. The true remainder is always below
    // the divisor, so the 32-bit subtraction cannot lose information.
    assign div_shift = {div_rem, div_quo[31]};
    assign div_ge    = (div_shift >= {1'b0, div_dvs});
    assign rem_next  = div_ge ? (div_shift[31:0] - div_dvs) : div_shift[31:0];
    assign quo_next  = {div_quo[30:0], div_ge};
    assign quo_final = div_neg_q ? (32'd0 - quo_next) : quo_next;
    assign rem_final = div_neg_r ? (32'd0 - rem_next) : rem_next;
    assign div_last  = (div_cnt == CNT_W'(DIV_CYCLES - 1));

    assign a_mag = (div_signed && Vi[31])  ? (32'd0 - Vi)  : Vi;
    assign b_mag = (div_signed && opb[31]) ? (32'd0 - opb) : opb;

    // ---------------- divider FSM ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_flag) begin
            state <= S_IDLE;
        end else if (rdy_in) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = start_div ? S_RUN : S_IDLE;
            S_RUN:   state_next = div_last ? S_DONE : S_RUN;
            S_DONE:  state_next = start_div ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath and result bus registers ----------------
    always_ff @(posedge clk_in) begin
        if (rst_in || clear_flag) begin
            rs_ready   <= 1'b0;
            rs_ROB_id  <= 5'd0;
            rs_val     <= 32'd0;
            br_valid   <= 1'b0;
            br_taken   <= 1'b0;
            br_target  <= 32'd0;
            div_rem    <= 32'd0;
            div_quo    <= 32'd0;
            div_dvs    <= 32'd0;
            div_cnt    <= '0;
            div_neg_q  <= 1'b0;
            div_neg_r  <= 1'b0;
            div_rem_op <= 1'b0;
            div_rd     <= 5'd0;
        end else if (rdy_in) begin
            rs_ready  <= 1'b0;
            rs_ROB_id <= 5'd0;
            rs_val    <= 32'd0;
            br_valid  <= 1'b0;
            br_taken  <= 1'b0;
            br_target <= 32'd0;
            if (state == S_RUN) begin
                div_rem <= rem_next;
                div_quo <= quo_next;
                if (div_last) begin
                    div_cnt   <= '0;
                    rs_ready  <= 1'b1;
                    rs_ROB_id <= div_rd;
                    rs_val    <= div_rem_op ? rem_final : quo_final;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end else if (start_div) begin
                div_rem    <= 32'd0;
                div_quo    <= a_mag;
                div_dvs    <= b_mag;
                div_cnt    <= '0;
                div_neg_q  <= div_signed && (Vi[31] ^ opb[31]);
                div_neg_r  <= div_signed && Vi[31];
                div_rem_op <= div_is_rem;
                div_rd     <= rd;
            end else if (sc_valid) begin
                rs_ready  <= 1'b1;
                rs_ROB_id <= rd;
                rs_val    <= sc_val;
                br_valid  <= sc_br;
                br_taken  <= sc_taken;
                br_target <= sc_target;
            end
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - scoreboard testbench for alu_unit
module tb_alu_unit;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        clear_flag;
    logic [6:0]  alu_op;
    logic [31:0] Vi, Vj, imm, pc;
    logic [4:0]  rd;
    logic        busy, rs_ready, br_valid, br_taken;
    logic [4:0]  rs_ROB_id;
    logic [31:0] rs_val, br_target;

    alu_unit #(.DIV_CYCLES(32)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear_flag (clear_flag),
        .alu_op     (alu_op),
        .Vi         (Vi),
        .Vj         (Vj),
        .imm        (imm),
        .rd         (rd),
        .pc         (pc),
        .busy       (busy),
        .rs_ready   (rs_ready),
        .rs_ROB_id  (rs_ROB_id),
        .rs_val     (rs_val),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    typedef struct {
        string       nm;
        int          cyc;
        logic [4:0]  id;
        logic [31:0] val;
        logic        bv;
        logic        bt;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented result is matched against the oldest expectation.
    always @(negedge clk_in) begin
        if (rs_ready !== 1'b0) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                failures = failures + 1;
                $display("FAIL unexpected_result: got rs_ready=%b id=%0d val=%h at cycle %0d, required no result",
                         rs_ready, rs_ROB_id, rs_val, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.nm, "_cycle"},  cyc,       mon_e.cyc);
                chk({mon_e.nm, "_id"},     rs_ROB_id, mon_e.id);
                chk({mon_e.nm, "_val"},    rs_val,    mon_e.val);
                chk({mon_e.nm, "_brv"},    br_valid,  mon_e.bv);
                chk({mon_e.nm, "_brt"},    br_taken,  mon_e.bt);
                chk({mon_e.nm, "_target"}, br_target, mon_e.tgt);
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic nop();
        alu_op = 7'd0; Vi = 32'd0; Vj = 32'd0; imm = 32'd0; rd = 5'd0; pc = 32'd0;
    endtask

    task automatic drive(input string nm, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [4:0] r, input logic [31:0] p,
                         input bit expect_out, input int lat, input logic [31:0] v,
                         input logic bv, input logic bt, input logic [31:0] t);
        alu_op = op; Vi = a; Vj = b; imm = im; rd = r; pc = p;
        if (expect_out) sb.push_back('{nm: nm, cyc: cyc + lat, id: r, val: v, bv: bv, bt: bt, tgt: t});
    endtask

    task automatic single(input string nm, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [4:0] r, input logic [31:0] p,
                          input logic [31:0] v, input logic bv, input logic bt, input logic [31:0] t);
        drive(nm, op, a, b, im, r, p, 1'b1, 1, v, bv, bt, t);
        #1 chk({nm, "_busy"}, busy, 1'b0);
        step();
        nop();
    endtask

    task automatic div_full(input string nm, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] r, input logic [31:0] v);
        drive(nm, op, a, b, 32'd0, r, 32'd0, 1'b1, 33, v, 1'b0, 1'b0, 32'd0);
        #1 chk({nm, "_busy"}, busy, 1'b1);
        step();
        nop();
        repeat (34) step();
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; clear_flag = 1'b0;
        nop();
        step();
        drive("add_in_reset", 7'd1, 32'd1, 32'd1, 32'd0, 5'd2, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(); nop(); step();
        chk("reset_rs_ready", rs_ready, 1'b0);
        chk("reset_rs_id",    rs_ROB_id, 5'd0);
        chk("reset_rs_val",   rs_val, 32'd0);
        chk("reset_br_valid", br_valid, 1'b0);
        chk("reset_br_taken", br_taken, 1'b0);
        chk("reset_br_target", br_target, 32'd0);
        chk("reset_busy",     busy, 1'b0);
        rst_in = 1'b0;
        step();

        // ---------------- single-cycle ops ----------------
        single("add",    7'd1,  32'd5, 32'hFFFF_FFFD, 32'd0, 5'd3, 32'd0, 32'd2, 1'b0, 1'b0, 32'd0);
        step();
        single("sra_imm", 7'h48, 32'h8000_0010, 32'd0, 32'd4, 5'd4, 32'd0, 32'hF800_0001, 1'b0, 1'b0, 32'd0);
        single("sltu",   7'd5,  32'd1, 32'hFFFF_FFFF, 32'd0, 5'd1, 32'd0, 32'd1, 1'b0, 1'b0, 32'd0);
        single("sub",    7'd2,  32'd3, 32'd5, 32'd0, 5'd2, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0);
        single("sll_imm_mask", 7'h43, 32'd1, 32'd0, 32'h21, 5'd5, 32'd0, 32'd2, 1'b0, 1'b0, 32'd0);
        single("slt",    7'd4,  32'hFFFF_FFFF, 32'd1, 32'd0, 5'd6, 32'd0, 32'd1, 1'b0, 1'b0, 32'd0);
        single("xor",    7'd6,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 5'd7, 32'd0, 32'h0FF0_0FF0, 1'b0, 1'b0, 32'd0);
        single("srl",    7'd7,  32'h8000_0000, 32'd4, 32'd0, 5'd8, 32'd0, 32'h0800_0000, 1'b0, 1'b0, 32'd0);
        single("or",     7'd9,  32'h0F, 32'hF0, 32'd0, 5'd9, 32'd0, 32'hFF, 1'b0, 1'b0, 32'd0);
        single("and",    7'd10, 32'h0F, 32'h3C, 32'd0, 5'd10, 32'd0, 32'h0C, 1'b0, 1'b0, 32'd0);
        single("lui",    7'd11, 32'd0, 32'd0, 32'h1234_5000, 5'd11, 32'd0, 32'h1234_5000, 1'b0, 1'b0, 32'd0);
        single("auipc",  7'd12, 32'd0, 32'd0, 32'h2000, 5'd12, 32'h1000, 32'h3000, 1'b0, 1'b0, 32'd0);
        single("jal",    7'd13, 32'd0, 32'd0, 32'h40, 5'd13, 32'h200, 32'h204, 1'b1, 1'b1, 32'h240);
        single("jalr",   7'd14, 32'h1003, 32'd0, 32'd0, 5'd14, 32'h40, 32'h44, 1'b1, 1'b1, 32'h1002);
        single("blt",    7'd17, 32'hFFFF_FFFF, 32'd1, 32'h20, 5'd15, 32'h100, 32'd0, 1'b1, 1'b1, 32'h120);
        single("beq_nt", 7'd15, 32'd5, 32'd6, 32'h20, 5'd16, 32'h100, 32'd0, 1'b1, 1'b0, 32'h104);
        single("bgeu",   7'd20, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 5'd17, 32'h300, 32'd0, 1'b1, 1'b1, 32'h2F0);
        single("mul",    7'd21, 32'd7, 32'hFFFF_FFFD, 32'd0, 5'd18, 32'd0, 32'hFFFF_FFEB, 1'b0, 1'b0, 32'd0);
        single("mulh",   7'd22, 32'h8000_0000, 32'h8000_0000, 32'd0, 5'd19, 32'd0, 32'h4000_0000, 1'b0, 1'b0, 32'd0);
        single("mulhsu", 7'd23, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd20, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        single("mulhu",  7'd24, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 5'd21, 32'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0);

        // Invalid op and NOP: no result on the bus.
        drive("bad_op", 7'd40, 32'd1, 32'd1, 32'd0, 5'd22, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(); nop(); step(); step();

        // ---------------- divide corner cases (single cycle) ----------------
        single("divu_by0", 7'd26, 32'd123, 32'd0, 32'd0, 5'd23, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
        single("remu_by0", 7'd28, 32'd123, 32'd0, 32'd0, 5'd24, 32'd0, 32'd123, 1'b0, 1'b0, 32'd0);
        single("div_ovf",  7'd25, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd25, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
        single("rem_ovf",  7'd27, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 5'd26, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        step();

        // ---------------- DIV with busy profile, ignored op, back-to-back ADD ----------------
        n0 = cyc;
        drive("div_neg", 7'd25, 32'hFFFF_FF9C, 32'd7, 32'd0, 5'd5, 32'd0, 1'b1, 33, 32'hFFFF_FFF2, 1'b0, 1'b0, 32'd0);
        #1 chk("div_busy_issue", busy, 1'b1);
        step(); nop();
        for (int k = 1; k <= 32; k++) begin
            if (k == 5)
                drive("ignored_add", 7'd1, 32'd1, 32'd1, 32'd0, 5'd9, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 32'd0);
            #1 chk("div_busy_run", busy, 1'b1);
            step(); nop();
        end
        chk("div_done_cycle_pos", cyc - n0, 33);
        single("add_after_div", 7'd1, 32'd1, 32'd1, 32'd0, 5'd6, 32'd0, 32'd2, 1'b0, 1'b0, 32'd0);
        step(); step();

        // ---------------- more divider results ----------------
        div_full("divu",      7'd26, 32'hFFFF_FFFF, 32'd10, 5'd10, 32'h1999_9999);
        div_full("rem_negdv", 7'd27, 32'd100, 32'hFFFF_FFF9, 5'd11, 32'd2);

        // ---------------- clear_flag aborts a running divide ----------------
        drive("div_clear", 7'd25, 32'd1000, 32'd3, 32'd0, 5'd12, 32'd0, 1'b0, 0, 32'd0, 1'b0, 1'b0, 32'd0);
        step(); nop();
        repeat (9) step();
        clear_flag = 1'b1;
        #1 chk("clear_busy_before", busy, 1'b1);
        step();
        clear_flag = 1'b0;
        #1 chk("clear_busy_after", busy, 1'b0);
        repeat (30) step();

        // ---------------- rdy_in stall during RUN ----------------
        drive("rem_stall", 7'd27, 32'hFFFF_FF9C, 32'd7, 32'd0, 5'd8, 32'd0, 1'b1, 38, 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0);
        step(); nop();
        for (int k = 1; k <= 40; k++) begin
            if (k == 10) rdy_in = 1'b0;
            if (k == 15) rdy_in = 1'b1;
            step();
        end

        repeat (3) step();
        chk("pending_results", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
